pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register that succeeds the fixed 32-bit IF/ID latch. It carries a data word and its PC between two pipeline stages using a valid/ready handshake. Flush drops the stage contents and presents a configurable NOP bubble. An optional one-entry skid buffer lets the backpressure path be registered. A saturating stall-cycle counter is included for performance monitoring, and the block is instantiated between any two stages (IF/ID, ID/EX, ...).

Parameters:
DATA_W, 32, width of the data/instruction field
PC_W, 32, width of the PC field
NOP_VAL, {DATA_W{1'b0}}, value driven on out_data_o whenever the stage holds no valid entry
SKID, 1, 1 = two-entry elastic stage (registered in_ready_o); 0 = single register with combinational ready
CNT_W, 16, width of the stall-cycle counter

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  global run enable; low freezes the stage
flush_i  input  1  synchronous flush of all stage contents
in_valid_i  input  1  upstream presents an entry
in_ready_o  output  1  stage can accept an entry this cycle
in_data_i  input  DATA_W  upstream data/instruction
in_pc_i  input  PC_W  upstream PC
out_valid_o  output  1  stage presents an entry downstream
out_ready_i  input  1  downstream accepts (low = stall)
out_data_o  output  DATA_W  head data, or NOP_VAL when empty
out_pc_o  output  PC_W  head PC, or 0 when empty
stall_cnt_o  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Definitions: accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- Update priority at each edge: rst_i, then flush_i, then start_i low (hold), then normal operation.
- Reset: all valid bits 0 and stall_cnt_o = 0. Outputs after reset: out_valid_o = 0, out_data_o = NOP_VAL, out_pc_o = 0. in_ready_o = 0 during reset while start_i is low, otherwise 1.
- Flush:
  - Clears the main and skid valid bits. Any entry offered on the flush cycle is dropped.
  - The next cycle shows out_valid_o = 0 and out_data_o = NOP_VAL.
  - stall_cnt_o is unaffected.
- start_i low:
  - in_ready_o = 0 and out_valid_o = 0, forced combinationally.
  - All state holds and stall_cnt_o does not count.
- Output mux: out_data_o = main_valid ? main_data : NOP_VAL; out_pc_o follows the same rule with 0.
- out_valid_o = main_valid & start_i.
- SKID=1 state machine over (main_valid, skid_valid); in_ready_o = ~skid_valid & start_i, no combinational path from out_ready_i.
  - EMPTY: accept -> ONE, main <= in.
  - ONE, accept & pop: stay ONE, main <= in.
  - ONE, accept & ~pop: -> FULL, skid <= in.
  - ONE, ~accept & pop: -> EMPTY.
  - ONE, neither: hold.
  - FULL: in_ready_o = 0. pop -> ONE with main <= skid; otherwise hold.
  - Order is strictly FIFO. A skid-valid-without-main-valid state is unreachable.
- SKID=0:
  - Single register, in_ready_o = (~main_valid | out_ready_i) & start_i.
  - accept loads main. pop without accept clears main.
  - Behaves as the legacy stall latch with a valid bit.
- Latency: an accepted entry appears on outputs the cycle after acceptance when the stage was empty or popping.
- Throughput: one entry per cycle under continuous out_ready_i, for both SKID values.
- stall_cnt_o increments by 1 each cycle with out_valid_o & ~out_ready_i. It saturates at all-ones and never wraps.
- Widths: all data/PC paths are exactly DATA_W/PC_W with no truncation or extension.
- Simultaneous flush with pop: the pop is honoured downstream (the head was visible), but the stage still empties.

Test Plan:
- Reset then stream: rst_i 1 for 2 cycles, start_i=1, out_ready_i=1, entries D=0x11,0x22,0x33 on consecutive cycles. Required: outputs one cycle later in order, out_valid_o continuous, in_ready_o stays 1.
- Skid fill (SKID=1): out_ready_i=0, offer 0xA1 then 0xA2. Required: in_ready_o drops to 0 the cycle after 0xA2 is accepted and 0xA3 is not accepted. When out_ready_i=1, output is 0xA1 then 0xA2, with stall_cnt_o = number of stalled valid cycles.
- Flush in FULL with in_valid_i=1: the next cycle shows out_valid_o=0, out_data_o=NOP_VAL (e.g. 0x00000013 when overridden), in_ready_o=1, and the flushed and incoming entries never appear.
- start_i low mid-stream with one entry held: out_valid_o=0 and in_ready_o=0, state frozen. When start_i returns to 1, the same entry and PC reappear and stall_cnt_o is unchanged.
- SKID=0 stall: out_ready_i=0 with main valid. Required: in_ready_o=0 combinationally. Raising out_ready_i with in_valid_i=1 in the same cycle pops the old entry and loads the new one, with no bubble.
- Counter saturation (CNT_W=4): stall for 20 cycles. Required: stall_cnt_o holds 15 and does not wrap; rst_i then clears it to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush-to-NOP,
// optional one-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int                 DATA_W  = 32,
    parameter int                 PC_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_VAL = {DATA_W{1'b0}},
    parameter int                 SKID    = 1,
    parameter int                 CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [PC_W-1:0]   in_pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and with SKID=1 ready never
    // depends on out_ready_i either.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam bit USE_SKID = (SKID != 0);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_data_q, main_data_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic main_valid;
    logic skid_valid;
    logic accept;
    logic pop;

    assign main_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_FULL);

    always_comb begin
        if (USE_SKID) begin
            in_ready_o = ~skid_valid & start_i;
        end else begin
            in_ready_o = (~main_valid | out_ready_i) & start_i;
        end
    end

    assign out_valid_o = main_valid & start_i;
    assign out_data_o  = main_valid ? main_data_q : NOP_VAL;
    assign out_pc_o    = main_valid ? main_pc_q : {PC_W{1'b0}};
    assign stall_cnt_o = stall_cnt_q;
    assign dbg_state_o = state_q;

    assign accept = in_valid_i & in_ready_o;
    assign pop    = out_valid_o & out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_pc_d   = main_pc_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        stall_cnt_d = stall_cnt_q;

        // Stalls are counted independently of flush; out_valid_o is already low while frozen.
        if (out_valid_o && !out_ready_i && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush_i) begin
            state_d = ST_EMPTY;
        end else if (start_i) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data_i;
                        main_pc_d   = in_pc_i;
                    end
                end
                ST_ONE: begin
                    if (accept && (pop || !USE_SKID)) begin
                        main_data_d = in_data_i;
                        main_pc_d   = in_pc_i;
                    end else if (accept) begin
                        state_d     = ST_FULL;
                        skid_data_d = in_data_i;
                        skid_pc_d   = in_pc_i;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_pc_d   = skid_pc_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Payload registers need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk_i) begin
        main_data_q <= main_data_d;
        main_pc_q   <= main_pc_d;
        skid_data_q <= skid_data_d;
        skid_pc_q   <= skid_pc_d;
    end

endmodule
